// File: rtl/hp_ctrl_pkg.sv
// rtl/hp_ctrl_pkg.sv - shared run-controller types and program start table
// Constants shared between the run controller and the core's Control decoder.
package hp_ctrl_pkg;

  localparam int PC_W       = 12;
  localparam int N_PROG     = 3;
  localparam int PROG_IDX_W = 2;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} run_state_t;

  localparam logic [PC_W-1:0] PROG_START [N_PROG] = '{12'h000, 12'h200, 12'h400};

  // Opcode Control decodes as halt; kept here so both sides agree.
  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  // Out-of-range program indices fall back to program 0.
  function automatic logic [PROG_IDX_W-1:0] map_prog(input logic [PROG_IDX_W-1:0] sel,
                                                     input int nprog);
    return (int'(sel) < nprog) ? sel : '0;
  endfunction

endpackage

// File: rtl/run_controller_start_lut.sv
// rtl/run_controller_start_lut.sv - program index to start address lookup
// Purely combinational; unknown indices resolve to the first program.
module start_lut
  import hp_ctrl_pkg::*;
(
  input  logic [PROG_IDX_W-1:0] prog_i,
  output logic [PC_W-1:0]       start_addr_o
);

  always_comb begin
    start_addr_o = PROG_START[0];
    for (int i = 0; i < N_PROG; i++) begin
      if (int'(prog_i) == i) start_addr_o = PROG_START[i];
    end
  end

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - sequences one program run: reset, PC load, run, halt, drain, done
// Optional RUN_TIMEOUT_EN adds a RUN-cycle timeout that ends the run with err set.
module run_controller
  import hp_ctrl_pkg::*;
#(
  parameter int D     = PC_W,
  parameter int NPROG = N_PROG,
  parameter int CW    = 16,
  parameter int TMO   = 4000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [PROG_IDX_W-1:0] prog_sel,
  input  logic                  halt,
  output logic                  core_rst,
  output logic                  pc_load,
  output logic [D-1:0]          start_addr,
  output logic                  run,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         cyc_cnt,
  output logic                  err
);

  run_state_t            state_q, state_d;
  logic [PROG_IDX_W-1:0] prog_q, prog_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic [PC_W-1:0]       lut_addr;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

`ifdef RUN_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_CNT = CW'(TMO);
  logic err_q, err_d;
`endif

  start_lut u_start_lut (
    .prog_i       (prog_q),
    .start_addr_o (lut_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prog_q  <= '0;
      cnt_q   <= '0;
`ifdef RUN_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      cnt_q   <= cnt_d;
`ifdef RUN_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    cnt_d   = cnt_q;
`ifdef RUN_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          prog_d  = map_prog(prog_sel, NPROG);
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
`ifdef RUN_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        state_d = RUN;
      end
      RUN: begin
        // The halt cycle itself is counted as a run cycle.
        cnt_d = cnt_inc;
        if (halt) begin
          state_d = DRAIN;
`ifdef RUN_TIMEOUT_EN
        end else if (cnt_inc >= TMO_CNT) begin
          err_d   = 1'b1;
          state_d = DONE;
`endif
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_rst   = (state_q == IDLE);
  assign pc_load    = (state_q == LOAD);
  assign run        = (state_q == RUN);
  assign busy       = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign start_addr = D'(lut_addr);
  assign cyc_cnt    = cnt_q;
`ifdef RUN_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - scoreboard bench for run_controller (set RUN_TIMEOUT_EN for timeout cases)
module tb_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [1:0]  prog_sel;
  logic        halt;
  logic        core_rst, pc_load, run, busy, done, err;
  logic [11:0] start_addr;
  logic [15:0] cyc_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] exp_addr_q [$];
  logic [15:0] exp_cnt_q  [$];
  logic        exp_err_q  [$];

  run_controller #(.TMO(50)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .prog_sel   (prog_sel),
    .halt       (halt),
    .core_rst   (core_rst),
    .pc_load    (pc_load),
    .start_addr (start_addr),
    .run        (run),
    .busy       (busy),
    .done       (done),
    .cyc_cnt    (cyc_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT loads a PC or raises done.
  logic done_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (pc_load === 1'b1) begin
        if (exp_addr_q.size() == 0) chk("unexpected_pc_load", 1, 0);
        else chk("start_addr", {20'h0, start_addr}, {20'h0, exp_addr_q.pop_front()});
      end
      if (done === 1'b1 && !done_prev) begin
        if (exp_cnt_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("cyc_cnt", {16'h0, cyc_cnt}, {16'h0, exp_cnt_q.pop_front()});
          chk("err", {31'h0, err}, {31'h0, exp_err_q.pop_front()});
        end
      end
      done_prev = (done === 1'b1);
    end
  end

  // Called at a negedge in IDLE; returns at the first negedge with done high.
  task automatic run_prog(input logic [1:0] sel, input logic [11:0] addr, input int nrun,
                          input bit halt_it, input bit exp_err);
    req = 1'b1;
    prog_sel = sel;
    exp_addr_q.push_back(addr);
    @(negedge clk);
    chk("pc_load_t+1", {31'h0, pc_load}, 1);
    chk("core_rst_load", {31'h0, core_rst}, 0);
    @(negedge clk);
    chk("run_t+2", {31'h0, run}, 1);
    repeat (nrun - 1) @(negedge clk);
    exp_cnt_q.push_back(16'(nrun));
    exp_err_q.push_back(exp_err);
    if (halt_it) begin
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      chk("drain_done", {31'h0, done}, 0);
      chk("drain_run", {31'h0, run}, 0);
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    chk("done_high", {31'h0, done}, 1);
  endtask

  task automatic hold_then_release(input int n, input bit halt_in_done);
    bit ok = 1'b1;
    halt = halt_in_done;
    repeat (n) begin
      @(negedge clk);
      if (done !== 1'b1 || pc_load !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    halt = 1'b0;
    chk("hold_done", {31'h0, ok}, 1);
    req = 1'b0;
    @(negedge clk);
    chk("idle_done", {31'h0, done}, 0);
    chk("idle_core_rst", {31'h0, core_rst}, 1);
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0;
    halt = 1'b0;
    prog_sel = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_core_rst", {31'h0, core_rst}, 1);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_start_addr", {20'h0, start_addr}, 32'h000);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cyc_cnt", {16'h0, cyc_cnt}, 0);
    chk("idle_err", {31'h0, err}, 0);

    // Program 1, halt on the 10th run cycle; req held high 20 cycles in DONE.
    run_prog(2'd1, 12'h200, 10, 1'b1, 1'b0);
    hold_then_release(20, 1'b0);

    // Program 2, short run; halt held during DONE must not change state.
    run_prog(2'd2, 12'h400, 3, 1'b1, 1'b0);
    hold_then_release(4, 1'b1);

    // Halt in IDLE is ignored.
    begin
      bit ok = 1'b1;
      halt = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (core_rst !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      halt = 1'b0;
      chk("halt_in_idle", {31'h0, ok}, 1);
    end

    // Out-of-range index maps to program 0; halt on the very first run cycle.
    run_prog(2'd3, 12'h000, 1, 1'b1, 1'b0);
    hold_then_release(1, 1'b0);

    // Asynchronous reset in the middle of RUN at cyc_cnt=5.
    req = 1'b1;
    prog_sel = 2'd1;
    exp_addr_q.push_back(12'h200);
    repeat (7) @(negedge clk);
    chk("mid_run_cnt", {16'h0, cyc_cnt}, 5);
    req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_core_rst", {31'h0, core_rst}, 1);
    chk("async_run", {31'h0, run}, 0);
    chk("async_done", {31'h0, done}, 0);
    chk("async_cyc_cnt", {16'h0, cyc_cnt}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", {31'h0, done}, 0);

    run_prog(2'd0, 12'h000, 4, 1'b1, 1'b0);
    hold_then_release(2, 1'b0);

`ifdef RUN_TIMEOUT_EN
    run_prog(2'd1, 12'h200, 50, 1'b0, 1'b1);
    hold_then_release(2, 1'b0);
    run_prog(2'd2, 12'h400, 50, 1'b1, 1'b0);
    hold_then_release(2, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_addr_empty", exp_addr_q.size(), 0);
    chk("sb_done_empty", exp_cnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
